// File: rtl/packetizer.sv
// ---------------------------------------------------------------------------
// packetizer
//
// Builds one modem frame per start request and streams it, one 2-bit symbol
// per transfer, to a downstream modulator:
//   training : TRN_LEN BPSK symbols 1,0,1,0,...
//   header   : 32 BPSK symbols, MSB first, {MCS, PLD_LEN, SIG}
//   payload  : PLD_LEN symbols taken from an AXI-Stream input, sent as QPSK
//              (MCS[7]=0) or BPSK (MCS[7]=1, bit taken from tdata[1]).
// A BPSK bit b is presented as sym_QPSK = {b,b} with is_bpsk high.
//
// Optional feature (compile-time macro):
//   PACKETIZER_DIFF_EN - payload symbols are differentially encoded against
//                        the previous payload output symbol (cleared to 00 at
//                        payload entry). Training and header are unaffected.
//
// Parameters:
//   BYTES    - byte width of the payload tdata bus (tdata is BYTES*8 bits)
//   TRN_LEN  - training symbols per frame (2..255)
//
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   start                     - one-cycle frame request, honoured only in IDLE
//   MCS, PLD_LEN, SIG         - header fields, latched on an accepted start
//   data_tdata/tvalid/tready/tlast - payload symbol stream (symbol in tdata[1:0])
//   sym_QPSK, sym_valid, sym_ready - symbol output with valid/ready handshake
//   is_bpsk                   - sym_QPSK currently carries a BPSK symbol
//   busy                      - a frame is in progress
//   len_err                   - one-cycle pulse when tlast disagrees with PLD_LEN
// ---------------------------------------------------------------------------
module packetizer #(
  parameter int BYTES   = 1,
  parameter int TRN_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           MCS,
  input  logic [15:0]          PLD_LEN,
  input  logic [7:0]           SIG,
  input  logic [BYTES*8-1:0]   data_tdata,
  input  logic                 data_tvalid,
  output logic                 data_tready,
  input  logic                 data_tlast,
  output logic [1:0]           sym_QPSK,
  output logic                 sym_valid,
  input  logic                 sym_ready,
  output logic                 is_bpsk,
  output logic                 busy,
  output logic                 len_err
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_TRN  = 4'b0010,
    ST_HDR  = 4'b0100,
    ST_PLD  = 4'b1000
  } state_t;

  localparam logic [7:0] TRN_LAST = 8'(TRN_LEN - 1);

  // Present one BPSK bit on both symbol lanes.
  function automatic logic [1:0] bpsk_sym(input logic b);
    return {b, b};
  endfunction

  state_t      state_r;
  logic [7:0]  mcs_r;
  logic [15:0] pld_len_r;
  logic [7:0]  sig_r;
  logic [7:0]  trn_cnt_r;
  logic [4:0]  hdr_cnt_r;
  logic [15:0] pld_cnt_r;

  logic        load_en_s;
  logic        pld_more_s;
  logic [31:0] hdr_word_s;
  logic        hdr_bit_s;
  logic        trn_bit_s;
  logic [15:0] pld_num_s;
  logic        pld_len_bad_s;
  logic [1:0]  pld_sym_s;

`ifdef PACKETIZER_DIFF_EN
  logic [1:0]  prev_out_r;
`endif

  // Upper tdata bits carry nothing for this block.
  logic unused_tdata_s;
  assign unused_tdata_s = ^data_tdata;

  // Handshake, header bit selection, length check and payload symbol mapping.
  always_comb begin
    // The output register may take a new symbol when empty or draining now.
    load_en_s   = !sym_valid || sym_ready;
    // Payload input is only requested until PLD_LEN symbols were accepted.
    pld_more_s  = (pld_cnt_r != pld_len_r);
    data_tready = (state_r == ST_PLD) && load_en_s && pld_more_s;

    hdr_word_s  = {mcs_r, pld_len_r, sig_r};
    hdr_bit_s   = hdr_word_s[5'd31 - hdr_cnt_r];
    trn_bit_s   = ~trn_cnt_r[0];

    // 1-based index of the symbol being accepted this cycle.
    pld_num_s   = pld_cnt_r + 16'd1;
    if (data_tlast) begin
      pld_len_bad_s = (pld_num_s != pld_len_r);
    end else begin
      pld_len_bad_s = (pld_num_s == pld_len_r);
    end

`ifdef PACKETIZER_DIFF_EN
    if (mcs_r[7]) begin
      pld_sym_s = bpsk_sym(data_tdata[1] ^ prev_out_r[1]);
    end else begin
      pld_sym_s = data_tdata[1:0] ^ prev_out_r;
    end
`else
    if (mcs_r[7]) begin
      pld_sym_s = bpsk_sym(data_tdata[1]);
    end else begin
      pld_sym_s = data_tdata[1:0];
    end
`endif
  end

  // Frame sequencer with the registered symbol output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      mcs_r     <= 8'd0;
      pld_len_r <= 16'd0;
      sig_r     <= 8'd0;
      trn_cnt_r <= 8'd0;
      hdr_cnt_r <= 5'd0;
      pld_cnt_r <= 16'd0;
      sym_QPSK  <= 2'b00;
      sym_valid <= 1'b0;
      is_bpsk   <= 1'b1;
      busy      <= 1'b0;
      len_err   <= 1'b0;
`ifdef PACKETIZER_DIFF_EN
      prev_out_r <= 2'b00;
`endif
    end else begin
      len_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mcs_r     <= MCS;
            pld_len_r <= PLD_LEN;
            sig_r     <= SIG;
            trn_cnt_r <= 8'd0;
            hdr_cnt_r <= 5'd0;
            pld_cnt_r <= 16'd0;
            busy      <= 1'b1;
            state_r   <= ST_TRN;
          end
        end

        ST_TRN: begin
          if (load_en_s) begin
            sym_QPSK  <= bpsk_sym(trn_bit_s);
            sym_valid <= 1'b1;
            is_bpsk   <= 1'b1;
            // Counter parks on the last index instead of wrapping.
            if (trn_cnt_r == TRN_LAST) begin
              state_r <= ST_HDR;
            end else begin
              trn_cnt_r <= trn_cnt_r + 8'd1;
            end
          end
        end

        ST_HDR: begin
          if (load_en_s) begin
            sym_QPSK  <= bpsk_sym(hdr_bit_s);
            sym_valid <= 1'b1;
            // Moving on once the 32nd bit is loaded lets the first payload
            // symbol load in the very cycle the last header bit transfers.
            // With PLD_LEN==0 the payload phase just waits for that transfer.
            if (hdr_cnt_r == 5'd31) begin
              state_r <= ST_PLD;
`ifdef PACKETIZER_DIFF_EN
              prev_out_r <= 2'b00;
`endif
            end else begin
              hdr_cnt_r <= hdr_cnt_r + 5'd1;
            end
          end
        end

        ST_PLD: begin
          if (load_en_s) begin
            if (pld_more_s) begin
              if (data_tvalid) begin
                sym_QPSK  <= pld_sym_s;
                sym_valid <= 1'b1;
                is_bpsk   <= mcs_r[7];
                pld_cnt_r <= pld_num_s;
                len_err   <= pld_len_bad_s;
`ifdef PACKETIZER_DIFF_EN
                prev_out_r <= pld_sym_s;
`endif
              end else begin
                // Underflow: no filler symbol, output simply goes idle.
                sym_valid <= 1'b0;
              end
            end else begin
              // All payload accepted and the final symbol transfers now.
              sym_valid <= 1'b0;
              is_bpsk   <= 1'b1;
              busy      <= 1'b0;
              state_r   <= ST_IDLE;
            end
          end
        end

        default: begin
          sym_valid <= 1'b0;
          is_bpsk   <= 1'b1;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
